fetch_decode_fsm: RTL and testbench

- Upstream controller for the per-class execution FSMs: the ALU 2-reg, ALU 1-reg, NOT, move, movi, load and store FSMs.
- Fetches one 16-bit instruction from memory using a request/MFC (memory-function-complete) handshake, latches it, and decodes the opcode.
- Launches the matching execution FSM with a single-cycle one-hot nextFSM pulse, drives the operand fields, and waits for that FSM's completion pulse before fetching the next instruction.

---
 rtl/fetch_decode_fsm_pkg.sv | 49 ++++
 rtl/fetch_decode_fsm_decoder.sv | 24 ++
 rtl/fetch_decode_fsm.sv | 122 ++++++++++++
 tb/tb_fetch_decode_fsm.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_fsm_pkg.sv
// Shared opcode, launch-code and field definitions for the
// fetch/decode controller and its execution FSM neighbours.
package fetch_decode_fsm_pkg;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam logic [3:0] paraAdd   = 4'b0001;
   localparam logic [3:0] paraSub   = 4'b0010;
   localparam logic [3:0] paraAnd   = 4'b0011;
   localparam logic [3:0] paraOr    = 4'b0100;
   localparam logic [3:0] paraXor   = 4'b0101;
   localparam logic [3:0] paraXnor  = 4'b0110;
   localparam logic [3:0] paraNot   = 4'b0111;
   localparam logic [3:0] paraAddi  = 4'b1000;
   localparam logic [3:0] paraSubi  = 4'b1001;
   localparam logic [3:0] paraMov   = 4'b1010;
   localparam logic [3:0] paraMovi  = 4'b1011;
   localparam logic [3:0] paraLoad  = 4'b1100;
   localparam logic [3:0] paraStore = 4'b1101;

   localparam logic [6:0] stateBlank   = 7'b0000000;
   localparam logic [6:0] stateAluPar2 = 7'b0000001;
   localparam logic [6:0] stateAluPar1 = 7'b0000010;
   localparam logic [6:0] stateAluNot  = 7'b0000100;
   localparam logic [6:0] stateMove    = 7'b0001000;
   localparam logic [6:0] stateMovi    = 7'b0010000;
   localparam logic [6:0] stateLoad    = 7'b0100000;
   localparam logic [6:0] stateStore   = 7'b1000000;
   localparam logic [6:0] stateError   = 7'b1111111;

   localparam int OP_HI = 15;
   localparam int OP_LO = 12;
   localparam int P1_HI = 11;
   localparam int P1_LO = 6;
   localparam int P2_HI = 5;
   localparam int P2_LO = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_DECODE,
      S_ISSUE,
      S_EXEC,
      S_ERROR
   } state_t;

endpackage

// File: rtl/fetch_decode_fsm_decoder.sv
// Opcode to one-hot execution FSM select; unused opcodes
// map to the all-ones error code.
module opcode_decoder
   import fetch_decode_fsm_pkg::*;
(
   input  logic [3:0] op,
   output logic [6:0] code
);

   always_comb begin
      code = stateError;
      unique case (1'b1)
         (op >= paraAdd && op <= paraXnor):   code = stateAluPar2;
         (op == paraAddi || op == paraSubi):  code = stateAluPar1;
         (op == paraNot):                     code = stateAluNot;
         (op == paraMov):                     code = stateMove;
         (op == paraMovi):                    code = stateMovi;
         (op == paraLoad):                    code = stateLoad;
         (op == paraStore):                   code = stateStore;
         default:                             code = stateError;
      endcase
   end

endmodule

// File: rtl/fetch_decode_fsm.sv
// Fetches, decodes and launches one instruction at a time,
// waiting on the launched FSM's done pulse before the next fetch.
module fetch_decode_fsm
   import fetch_decode_fsm_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int TIMEOUT     = 32,
   parameter int MFC_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   output logic              memRd,
   output logic [ADDR_W-1:0] memAddr,
   input  logic [15:0]       memData,
   input  logic              mfc,
   input  logic [6:0]        doneVec,
   output logic [6:0]        nextFSM,
   output logic [5:0]        para1,
   output logic [5:0]        para2,
   output logic [ADDR_W-1:0] pc,
   output logic              err
);

   localparam int WCW = $clog2(MFC_TIMEOUT + 1);
   localparam int XCW = $clog2(TIMEOUT + 1);
   localparam logic [WCW-1:0] WLIM = WCW'(MFC_TIMEOUT - 1);
   localparam logic [XCW-1:0] XLIM = XCW'(TIMEOUT - 1);

   state_t         state;
   state_t         nxt;
   logic [15:0]    ir;
   logic [6:0]     code;
   logic [6:0]     dec;
   logic [WCW-1:0] wcnt;
   logic [XCW-1:0] xcnt;
   logic           hit;

   opcode_decoder u_dec (
      .op   (ir[OP_HI:OP_LO]),
      .code (dec)
   );

   assign memAddr = pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt     = state;
      memRd   = FALSE;
      nextFSM = stateBlank;
      err     = FALSE;
      hit     = |(doneVec & code);
      unique case (state)
         S_IDLE: begin
            if (go) nxt = S_FETCH;
         end
         S_FETCH: begin
            memRd = TRUE;
            nxt   = S_WAIT;
         end
         S_WAIT: begin
            memRd = TRUE;
            if (mfc)               nxt = S_DECODE;
            else if (wcnt == WLIM) nxt = S_ERROR;
         end
         S_DECODE: begin
            nxt = (dec == stateError) ? S_ERROR : S_ISSUE;
         end
         S_ISSUE: begin
            nextFSM = code;
            nxt     = S_EXEC;
         end
         S_EXEC: begin
            if (hit)               nxt = S_FETCH;
            else if (xcnt == XLIM) nxt = S_ERROR;
         end
         S_ERROR: begin
            err     = TRUE;
            nextFSM = stateError;
         end
         default: nxt = S_ERROR;
      endcase
   end

   // code holds the issued select so EXEC can mask unrelated done bits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc    <= '0;
         ir    <= '0;
         para1 <= '0;
         para2 <= '0;
         code  <= stateBlank;
         wcnt  <= '0;
         xcnt  <= '0;
      end else begin
         unique case (state)
            S_FETCH: wcnt <= '0;
            S_WAIT: begin
               if (mfc) begin
                  ir <= memData;
                  pc <= pc + ADDR_W'(1);
               end else begin
                  wcnt <= wcnt + WCW'(1);
               end
            end
            S_DECODE: begin
               para1 <= ir[P1_HI:P1_LO];
               para2 <= ir[P2_HI:P2_LO];
               code  <= dec;
            end
            S_ISSUE: xcnt <= '0;
            S_EXEC:  xcnt <= xcnt + XCW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_decode_fsm.sv
// Scoreboard bench for fetch_decode_fsm: directed programs,
// memory/exec responders and a decoupled output monitor.
module tb_fetch_decode_fsm;

   localparam int AW = 8;

   typedef struct packed {
      logic [6:0]    code;
      logic [5:0]    p1;
      logic [5:0]    p2;
      logic [AW-1:0] pc;
   } launch_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          go = 1'b0;
   logic          memRd;
   logic [AW-1:0] memAddr;
   logic [15:0]   memData = '0;
   logic          mfc = 1'b0;
   logic [6:0]    doneVec;
   logic [6:0]    nextFSM;
   logic [5:0]    para1;
   logic [5:0]    para2;
   logic [AW-1:0] pc;
   logic          err;

   logic [15:0]   mem [256];
   launch_t       lq[$];
   logic [AW-1:0] fq[$];

   int checks = 0;
   int errors = 0;
   int lat = 1;
   int dly = 1;
   bit hold = 1'b0;
   bit auto_on = 1'b1;
   int mcnt = 0;
   int acnt = 0;
   int run = 0;
   int last_run = 0;
   logic [6:0] acode = '0;
   logic [6:0] done_auto = '0;
   logic [6:0] done_man = '0;
   logic [6:0] prev_n = '0;
   logic       prev_rd = 1'b0;

   assign doneVec = done_auto | done_man;

   fetch_decode_fsm #(
      .ADDR_W      (AW),
      .TIMEOUT     (32),
      .MFC_TIMEOUT (16)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .go      (go),
      .memRd   (memRd),
      .memAddr (memAddr),
      .memData (memData),
      .mfc     (mfc),
      .doneVec (doneVec),
      .nextFSM (nextFSM),
      .para1   (para1),
      .para2   (para2),
      .pc      (pc),
      .err     (err)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name,
                               input logic [63:0] act,
                               input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endfunction

   function automatic logic [6:0] ref_code(input logic [3:0] op);
      case (op)
         4'h1, 4'h2, 4'h3,
         4'h4, 4'h5, 4'h6: return 7'b0000001;
         4'h8, 4'h9:       return 7'b0000010;
         4'h7:             return 7'b0000100;
         4'hA:             return 7'b0001000;
         4'hB:             return 7'b0010000;
         4'hC:             return 7'b0100000;
         4'hD:             return 7'b1000000;
         default:          return 7'b1111111;
      endcase
   endfunction

   // memory: mfc on the lat-th WAIT cycle unless held off
   always @(negedge clk) begin
      if (memRd) mcnt = mcnt + 1;
      else       mcnt = 0;
      mfc     = memRd && !hold && (mcnt == lat + 1);
      memData = mem[memAddr];
   end

   // execution FSM stand-in: done pulse dly cycles after launch
   always @(negedge clk) begin
      done_auto = '0;
      if (rst) begin
         acnt = 0;
      end else if (acnt > 0) begin
         acnt = acnt - 1;
         if (acnt == 0) done_auto = acode;
      end else if (auto_on && nextFSM != 7'h00 && nextFSM != 7'h7F) begin
         acode = nextFSM;
         acnt  = dly;
      end
   end

   always @(negedge clk) begin
      launch_t e;
      if (rst) begin
         prev_n  = '0;
         prev_rd = 1'b0;
         run     = 0;
      end else begin
         if (memRd && !prev_rd) begin
            if (fq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL fetch_unexpected: got addr %0h want none", memAddr);
            end else begin
               chk("fetch_addr", 64'(memAddr), 64'(fq.pop_front()));
            end
         end
         if (memRd) run = prev_rd ? run + 1 : 1;
         else if (prev_rd) last_run = run;
         if (nextFSM != 7'h00 && prev_n == 7'h00) begin
            if (lq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL launch_unexpected: got %b want none", nextFSM);
            end else begin
               e = lq.pop_front();
               chk("launch_code", 64'(nextFSM), 64'(e.code));
               chk("launch_para1", 64'(para1), 64'(e.p1));
               chk("launch_para2", 64'(para2), 64'(e.p2));
               chk("launch_pc", 64'(pc), 64'(e.pc));
               chk("launch_err", 64'(err), 64'(e.code == 7'h7F));
            end
         end else if (prev_n == 7'h7F) begin
            chk("error_hold", 64'({err, nextFSM, memRd}), 64'({1'b1, 7'h7F, 1'b0}));
         end else if (prev_n != 7'h00) begin
            chk("pulse_width", 64'(nextFSM), 64'(0));
         end
         prev_n  = nextFSM;
         prev_rd = memRd;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic exp_launch(input logic [6:0] c, input logic [5:0] a,
                             input logic [5:0] b, input logic [AW-1:0] p);
      launch_t e;
      e.code = c;
      e.p1   = a;
      e.p2   = b;
      e.pc   = p;
      lq.push_back(e);
   endtask

   task automatic assert_rst(input string name);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk(name, 64'({memRd, memAddr, nextFSM, para1, para2, pc, err}), 64'(0));
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic do_reset();
      hold     = 1'b0;
      auto_on  = 1'b1;
      dly      = 1;
      lat      = 1;
      done_man = '0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      assert_rst("reset_outputs");
   endtask

   task automatic pulse_go();
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic wait_err(input string name, input int budget);
      int n;
      n = 0;
      while (err !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, 64'(err), 64'(1));
   endtask

   task automatic wait_launch(input string name, input int budget);
      int n;
      n = 0;
      while ((nextFSM == 7'h00 || nextFSM == 7'h7F) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, 64'(nextFSM != 7'h00 && nextFSM != 7'h7F), 64'(1));
   endtask

   task automatic drain(input string name);
      tick(3);
      chk({name, "_launch_q"}, 64'(lq.size()), 64'(0));
      chk({name, "_fetch_q"}, 64'(fq.size()), 64'(0));
      lq.delete();
      fq.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   initial begin
      logic [3:0]    op;
      logic [5:0]    a;
      logic [5:0]    b;
      logic [6:0]    c;
      logic [AW-1:0] ad;
      int            n;

      // add 1,3 with a two-cycle memory wait
      do_reset();
      mem[0] = 16'h1043;
      lat = 2;
      fq.push_back(8'd0);
      exp_launch(7'b0000001, 6'd1, 6'd3, 8'd1);
      fq.push_back(8'd1);
      exp_launch(7'h7F, 6'd0, 6'd0, 8'd2);
      pulse_go();
      wait_launch("t1_launch", 50);
      chk("t1_memrd_cycles", 64'(last_run), 64'(3));
      wait_err("t1_err", 50);
      drain("t1");

      // opcode sweep
      for (int k = 0; k < 16; k++) begin
         do_reset();
         op = k[3:0];
         a  = 6'(k * 5);
         b  = 6'(63 - k);
         c  = ref_code(op);
         mem[0] = {op, a, b};
         fq.push_back(8'd0);
         exp_launch(c, a, b, 8'd1);
         if (c != 7'h7F) begin
            fq.push_back(8'd1);
            exp_launch(7'h7F, 6'd0, 6'd0, 8'd2);
         end
         pulse_go();
         wait_err($sformatf("sweep%0d_err", k), 60);
         tick(2);
         chk($sformatf("sweep%0d_hold", k), 64'({nextFSM, memRd}), 64'({7'h7F, 1'b0}));
         drain($sformatf("sweep%0d", k));
      end

      // movi ignores ISSUE-cycle and foreign done bits
      do_reset();
      auto_on = 1'b0;
      mem[0] = 16'hB0C5;
      fq.push_back(8'd0);
      exp_launch(7'b0010000, 6'd3, 6'd5, 8'd1);
      fq.push_back(8'd1);
      exp_launch(7'h7F, 6'd0, 6'd0, 8'd2);
      pulse_go();
      wait_launch("movi_launch", 50);
      done_man = 7'b0010000;
      @(negedge clk);
      done_man = 7'b0000001;
      @(negedge clk);
      done_man = 7'b0000000;
      tick(2);
      chk("movi_no_advance", 64'({memRd, nextFSM}), 64'(0));
      done_man = 7'b0010000;
      @(negedge clk);
      done_man = 7'b0000000;
      chk("movi_advance", 64'(memRd), 64'(1));
      wait_err("movi_err", 50);
      drain("movi");

      // mfc withheld
      do_reset();
      hold = 1'b1;
      fq.push_back(8'd0);
      exp_launch(7'h7F, 6'd0, 6'd0, 8'd0);
      pulse_go();
      wait_err("mfc_timeout_err", 40);
      @(negedge clk);
      chk("mfc_timeout_rd_cycles", 64'(last_run), 64'(17));
      drain("mfc_timeout");

      // done withheld
      do_reset();
      auto_on = 1'b0;
      mem[0] = 16'h1043;
      fq.push_back(8'd0);
      exp_launch(7'b0000001, 6'd1, 6'd3, 8'd1);
      exp_launch(7'h7F, 6'd1, 6'd3, 8'd1);
      pulse_go();
      wait_launch("exec_timeout_launch", 50);
      n = 0;
      while (err !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("exec_timeout_cycles", 64'(n), 64'(33));
      drain("exec_timeout");

      // pc wrap 255 -> 0
      do_reset();
      for (int i = 0; i < 255; i++) begin
         ad = i[7:0];
         mem[i] = {4'hA, ad[5:0], ad[7:2]};
         fq.push_back(ad);
         exp_launch(7'b0001000, ad[5:0], ad[7:2], ad + 8'd1);
      end
      mem[255] = 16'h1043;
      fq.push_back(8'd255);
      exp_launch(7'b0000001, 6'd1, 6'd3, 8'd0);
      fq.push_back(8'd0);
      exp_launch(7'h7F, 6'd0, 6'd0, 8'd1);
      pulse_go();
      wait_launch("wrap_first", 50);
      mem[0] = 16'h0000;
      wait_err("wrap_err", 2000);
      drain("wrap");

      // reset during WAIT
      do_reset();
      hold = 1'b1;
      mem[0] = 16'h1043;
      fq.push_back(8'd0);
      pulse_go();
      tick(3);
      assert_rst("rst_wait_outputs");
      hold = 1'b0;
      tick(20);
      chk("rst_wait_quiet", 64'({memRd, nextFSM, err}), 64'(0));
      drain("rst_wait");

      // reset during EXEC
      do_reset();
      auto_on = 1'b0;
      mem[0] = 16'h1043;
      fq.push_back(8'd0);
      exp_launch(7'b0000001, 6'd1, 6'd3, 8'd1);
      pulse_go();
      wait_launch("rst_exec_launch", 50);
      tick(3);
      assert_rst("rst_exec_outputs");
      tick(20);
      chk("rst_exec_quiet", 64'({memRd, nextFSM, err, pc}), 64'(0));
      drain("rst_exec");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
